// File: rtl/draw_rect_ctl_if.sv
`default_nettype none
// vga_if: VGA timing and pixel bus passed between pipeline stages.

interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in_mp  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out_mp (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_rect_ctl.sv
`default_nettype none
// draw_rect_ctl: Jump King character motion controller (charge/jump/fall FSM,
// wall bounce, one platform, level wrap) with a one-stage VGA pass-through.

module draw_rect_ctl #(
  parameter int SCREEN_WIDTH  = 1024,
  parameter int SCREEN_HEIGHT = 786,
  parameter int REC_WIDTH     = 47,
  parameter int REC_HEIGHT    = 63,
  parameter int TICK_CYCLES   = 1,
  parameter int MAX_JUMP      = 20,
  parameter int H_JUMP        = 4,
  parameter int MAX_FALL      = 20,
  parameter int PLAT_X0       = 400,
  parameter int PLAT_X1       = 623,
  parameter int PLAT_Y        = 600,
  parameter int PLAT_H        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_space,
  input  logic        key_left,
  input  logic        key_right,
  output logic [11:0] value_x,
  output logic [11:0] value_y,
  output logic [1:0]  character_state,
  output logic [1:0]  level,
  vga_if.in_mp        vga_in,
  vga_if.out_mp       vga_out
);

  localparam logic signed [12:0] GROUND     = 13'(SCREEN_HEIGHT - REC_HEIGHT);
  localparam logic signed [12:0] XMAX       = 13'(SCREEN_WIDTH - REC_WIDTH - 1);
  localparam logic signed [12:0] X_RESET    = 13'((SCREEN_WIDTH - REC_WIDTH) / 2);
  localparam logic signed [12:0] PLAT_TOP   = 13'(PLAT_Y - REC_HEIGHT);
  localparam logic signed [12:0] PLAT_UNDER = 13'(PLAT_Y + PLAT_H);
  localparam logic signed [12:0] PX0        = 13'(PLAT_X0);
  localparam logic signed [12:0] PX1        = 13'(PLAT_X1);
  localparam logic signed [12:0] RW         = 13'(REC_WIDTH);
  localparam logic signed [12:0] HJ         = 13'(H_JUMP);
  localparam logic [7:0]         MAXJ       = 8'(MAX_JUMP);
  localparam logic [7:0]         MAXF       = 8'(MAX_FALL);
  localparam int                 TCW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FALLING   = 3'd1,
    JUMP      = 3'd2,
    LEFT      = 3'd3,
    RIGHT     = 3'd4,
    JUMP_PREP = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [11:0]        x_q, x_d, y_q, y_d;
  logic [1:0]         level_q, level_d, cs_q, cs_d;
  logic signed [1:0]  dir_q, dir_d, dir_bounce;
  logic [7:0]         jump_vel, jump_vel_nxt, vel_time, vel_time_nxt, vt_inc, vt_fall;
  logic signed [12:0] y_jump_start, y_jump_start_nxt;
  logic [TCW-1:0]     tick_cnt_q;
  logic               tick, overlap, has_bottom, collision_bot;
  logic signed [12:0] x_s, y_s, fall_bottom, x_step, x_drift, y_up, y_dn;

  assign x_s     = $signed({1'b0, x_q});
  assign y_s     = $signed({1'b0, y_q});
  assign tick    = (tick_cnt_q == TCW'(TICK_CYCLES - 1));
  assign overlap = ((x_s + RW) > PX0) && (x_s < PX1);
  assign vt_inc  = vel_time + 8'd1;
  assign vt_fall = (vel_time >= MAXF) ? MAXF : vt_inc;
  assign y_up    = y_s - ($signed({5'd0, jump_vel}) - $signed({5'd0, vel_time}));
  assign y_dn    = y_s + $signed({5'd0, vt_fall});

  // Landing surface below the character; levels above 0 have no ground.
  always_comb begin
    has_bottom  = 1'b1;
    fall_bottom = GROUND;
    if (overlap && (y_s <= PLAT_TOP)) begin
      fall_bottom = PLAT_TOP;
    end else if (level_q != 2'd0) begin
      has_bottom = 1'b0;
    end
  end
  assign collision_bot = has_bottom && (y_s == fall_bottom);

  always_comb begin
    dir_bounce = dir_q;
    case (dir_q)
      2'sb01:  x_step = HJ;
      2'sb11:  x_step = -HJ;
      default: x_step = 13'sd0;
    endcase
    x_drift = x_s + x_step;
    if (x_drift < 13'sd0) begin
      x_drift    = 13'sd0;
      dir_bounce = -dir_q;
    end else if (x_drift > XMAX) begin
      x_drift    = XMAX;
      dir_bounce = -dir_q;
    end
  end

  always_comb begin
    state_nxt        = state;
    x_d              = x_q;
    y_d              = y_q;
    level_d          = level_q;
    dir_d            = dir_q;
    jump_vel_nxt     = jump_vel;
    vel_time_nxt     = vel_time;
    y_jump_start_nxt = y_jump_start;
    case (state)
      IDLE, LEFT, RIGHT: begin
        if (!collision_bot) begin
          state_nxt    = FALLING;
          vel_time_nxt = 8'd0;
        end else if (key_space) begin
          state_nxt    = JUMP_PREP;
          jump_vel_nxt = 8'd1;
          dir_d        = 2'sb00;
        end else if (key_left && (state != RIGHT)) begin
          state_nxt = LEFT;
          x_d       = (x_s > 13'sd0) ? 12'(x_s - 13'sd1) : 12'd0;
        end else if (key_right && (state != LEFT)) begin
          state_nxt = RIGHT;
          x_d       = (x_s < XMAX) ? 12'(x_s + 13'sd1) : 12'(XMAX);
        end else begin
          state_nxt = IDLE;
        end
      end
      JUMP_PREP: begin
        if (key_left && !key_right) dir_d = 2'sb11;
        else if (key_right && !key_left) dir_d = 2'sb01;
        if (key_space) begin
          jump_vel_nxt = (jump_vel >= MAXJ) ? MAXJ : jump_vel + 8'd1;
        end else begin
          state_nxt        = JUMP;
          y_jump_start_nxt = y_s;
          vel_time_nxt     = 8'd0;
        end
      end
      JUMP: begin
        x_d          = 12'(x_drift);
        dir_d        = dir_bounce;
        vel_time_nxt = vt_inc;
        // A jump that began below the platform can only hit its underside.
        if (overlap && (y_jump_start >= PLAT_UNDER) && (y_s >= PLAT_UNDER) &&
            (y_up < PLAT_UNDER)) begin
          y_d          = 12'(PLAT_UNDER);
          state_nxt    = FALLING;
          vel_time_nxt = 8'd0;
        end else begin
          if (y_up < 13'sd0) begin
            if (level_q != 2'd3) begin
              level_d          = level_q + 2'd1;
              y_d              = 12'(y_up + GROUND);
              y_jump_start_nxt = y_jump_start + GROUND;
            end else begin
              y_d          = 12'd0;
              state_nxt    = FALLING;
              vel_time_nxt = 8'd0;
            end
          end else begin
            y_d = 12'(y_up);
          end
          if (jump_vel == vt_inc) begin
            state_nxt    = FALLING;
            vel_time_nxt = 8'd0;
          end
        end
      end
      FALLING: begin
        x_d          = 12'(x_drift);
        dir_d        = dir_bounce;
        vel_time_nxt = vt_fall;
        if (has_bottom && (y_dn >= fall_bottom)) begin
          y_d          = 12'(fall_bottom);
          state_nxt    = IDLE;
          jump_vel_nxt = 8'd0;
          dir_d        = 2'sb00;
        end else if (!has_bottom && (y_dn > GROUND)) begin
          level_d = level_q - 2'd1;
          y_d     = 12'(y_dn - GROUND);
        end else begin
          y_d = 12'(y_dn);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state_nxt)
      IDLE:         cs_d = 2'd0;
      JUMP_PREP:    cs_d = 2'd1;
      LEFT, RIGHT:  cs_d = 2'd3;
      default:      cs_d = 2'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x_q          <= 12'(X_RESET);
      y_q          <= 12'(GROUND);
      level_q      <= 2'd0;
      cs_q         <= 2'd0;
      dir_q        <= 2'sb00;
      jump_vel     <= 8'd0;
      vel_time     <= 8'd0;
      y_jump_start <= GROUND;
      tick_cnt_q   <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TCW'(1);
      if (tick) begin
        state        <= state_nxt;
        x_q          <= x_d;
        y_q          <= y_d;
        level_q      <= level_d;
        cs_q         <= cs_d;
        dir_q        <= dir_d;
        jump_vel     <= jump_vel_nxt;
        vel_time     <= vel_time_nxt;
        y_jump_start <= y_jump_start_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= vga_in.vcount;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.hcount <= vga_in.hcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.rgb    <= vga_in.rgb;
    end
  end

  assign value_x         = x_q;
  assign value_y         = y_q;
  assign level           = level_q;
  assign character_state = cs_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_rect_ctl.sv
`default_nettype none
// tb_draw_rect_ctl: directed + random key stimulus, reference model feeding a
// scoreboard queue that a separate monitor drains every clock.

module tb_draw_rect_ctl;

  localparam int GROUND = 723, XMAX = 976, PX0 = 400, PX1 = 623;
  localparam int PTOP = 537, PUNDER = 616, W = 47;
  localparam int M_STAND = 0, M_PREP = 1, M_UP = 2, M_DOWN = 3, M_WALKL = 4, M_WALKR = 5;

  logic        clk = 1'b0, rst = 1'b1;
  logic        key_space = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [11:0] value_x, value_y;
  logic [1:0]  character_state, level;

  vga_if vin();
  vga_if vout();

  draw_rect_ctl dut (
    .clk(clk), .rst(rst),
    .key_space(key_space), .key_left(key_left), .key_right(key_right),
    .value_x(value_x), .value_y(value_y),
    .character_state(character_state), .level(level),
    .vga_in(vin), .vga_out(vout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    int          cs;
    int          lev;
    logic [37:0] vga;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: character position and motion mode as plain integers.
  int mx, my, mlev, mjv, mvt, mdir, mmode;

  function automatic bit over(input int x);
    return (x + W > PX0) && (x < PX1);
  endfunction

  function automatic int floor_at(input int x, input int y, input int lev);
    if (over(x) && y <= PTOP) return PTOP;
    if (lev == 0) return GROUND;
    return -1;
  endfunction

  function automatic int mode_cs(input int m);
    case (m)
      M_STAND: return 0;
      M_PREP:  return 1;
      M_UP, M_DOWN: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    mx = 488; my = GROUND; mlev = 0; mjv = 0; mvt = 0; mdir = 0; mmode = M_STAND;
  endtask

  task automatic drift();
    int nx;
    nx = mx + mdir * 4;
    if (nx < 0) begin mx = 0; mdir = -mdir; end
    else if (nx > XMAX) begin mx = XMAX; mdir = -mdir; end
    else mx = nx;
  endtask

  task automatic model_tick(input bit sp, input bit l, input bit r);
    int fl, ny;
    bit ov, grounded, walking;
    fl = floor_at(mx, my, mlev);
    ov = over(mx);
    grounded = (fl == my);
    walking = (mmode == M_WALKL) || (mmode == M_WALKR);
    if (mmode == M_STAND || walking) begin
      if (!grounded) begin mmode = M_DOWN; mvt = 0; end
      else if (sp) begin mmode = M_PREP; mjv = 1; mdir = 0; end
      else if (l && mmode != M_WALKR) begin mmode = M_WALKL; mx = (mx > 0) ? mx - 1 : 0; end
      else if (r && mmode != M_WALKL) begin mmode = M_WALKR; mx = (mx < XMAX) ? mx + 1 : XMAX; end
      else mmode = M_STAND;
    end else if (mmode == M_PREP) begin
      if (l && !r) mdir = -1;
      else if (r && !l) mdir = 1;
      if (sp) mjv = (mjv < 20) ? mjv + 1 : 20;
      else begin mmode = M_UP; mvt = 0; end
    end else if (mmode == M_UP) begin
      ny = my - (mjv - mvt);
      mvt++;
      drift();
      if (ov && my >= PUNDER && ny < PUNDER) begin
        my = PUNDER; mmode = M_DOWN; mvt = 0;
      end else begin
        if (ny < 0) begin
          if (mlev < 3) begin mlev++; my = ny + GROUND; end
          else begin my = 0; mmode = M_DOWN; mvt = 0; end
        end else my = ny;
        if (mmode == M_UP && mvt == mjv) begin mmode = M_DOWN; mvt = 0; end
      end
    end else begin
      mvt = (mvt < 20) ? mvt + 1 : 20;
      ny = my + mvt;
      drift();
      if (fl >= 0 && ny >= fl) begin
        my = fl; mmode = M_STAND; mjv = 0; mdir = 0;
      end else if (fl < 0 && ny > GROUND) begin
        mlev--; my = ny - GROUND;
      end else my = ny;
    end
  endtask

  task automatic step(input bit sp, input bit l, input bit r, input bit rs);
    exp_t e;
    @(negedge clk);
    key_space = sp; key_left = l; key_right = r; rst = rs;
    vin.vcount = 11'($urandom); vin.hcount = 11'($urandom);
    vin.vsync = 1'($urandom); vin.vblnk = 1'($urandom);
    vin.hsync = 1'($urandom); vin.hblnk = 1'($urandom);
    vin.rgb = 12'($urandom);
    if (rs) model_reset();
    else model_tick(sp, l, r);
    e.x = mx; e.y = my; e.cs = mode_cs(mmode); e.lev = mlev;
    e.vga = rs ? 38'd0 : {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync, vin.hblnk, vin.rgb};
    sb_q.push_back(e);
  endtask

  task automatic hold(input bit sp, input bit l, input bit r, input int n);
    repeat (n) step(sp, l, r, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("x", longint'(value_x), mon_e.x);
      chk("y", longint'(value_y), mon_e.y);
      chk("character_state", longint'(character_state), mon_e.cs);
      chk("level", longint'(level), mon_e.lev);
      chk("vga_out", longint'({vout.vcount, vout.vsync, vout.vblnk, vout.hcount,
                               vout.hsync, vout.hblnk, vout.rgb}), longint'(mon_e.vga));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    bit sp, l, r;
    int len;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    hold(0, 0, 0, 10);
    settle();
    chk("reset_x", longint'(value_x), 488);
    chk("reset_y", longint'(value_y), 723);

    hold(0, 1, 0, 50);
    settle();
    chk("walk_left_50", longint'(value_x), 438);
    hold(0, 1, 0, 338);
    hold(0, 0, 0, 1);

    hold(1, 0, 0, 1000);
    settle();
    chk("charge_state", longint'(character_state), 1);
    chk("charge_sat", longint'(dut.jump_vel), 20);
    hold(0, 0, 0, 21);
    settle();
    chk("apex_y", longint'(value_y), 513);
    hold(0, 0, 0, 20);
    settle();
    chk("land_ground_y", longint'(value_y), 723);
    chk("land_ground_cs", longint'(character_state), 0);

    hold(0, 0, 1, 870);
    settle();
    chk("walk_right_970", longint'(value_x), 970);
    hold(0, 0, 1, 100);
    settle();
    chk("right_wall", longint'(value_x), 976);
    hold(0, 0, 0, 1);
    settle();
    chk("release_idle", longint'(character_state), 0);

    hold(0, 1, 0, 488);
    hold(0, 0, 0, 1);
    hold(1, 0, 0, 25);
    hold(0, 0, 0, 8);
    settle();
    chk("underside_y", longint'(value_y), 616);
    hold(0, 0, 0, 15);
    settle();
    chk("underside_land_y", longint'(value_y), 723);

    hold(0, 1, 0, 168);
    hold(0, 0, 0, 1);
    hold(1, 0, 1, 25);
    hold(0, 0, 0, 28);
    settle();
    chk("plat_land_y", longint'(value_y), 537);
    chk("plat_land_x", longint'(value_x), 428);
    chk("plat_collision", longint'(dut.collision_bot), 1);
    hold(0, 0, 1, 195);
    settle();
    chk("plat_edge_x", longint'(value_x), 623);
    hold(0, 0, 0, 20);
    settle();
    chk("walk_off_land_y", longint'(value_y), 723);

    hold(1, 0, 0, 5);
    hold(0, 0, 0, 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("midjump_rst_x", longint'(value_x), 488);
    chk("midjump_rst_y", longint'(value_y), 723);
    chk("midjump_rst_cs", longint'(character_state), 0);
    chk("midjump_rst_vel", longint'(dut.jump_vel), 0);

    for (int k = 0; k < 120; k++) begin
      len = $urandom_range(1, 40);
      sp = ($urandom_range(0, 2) == 0);
      l = 1'($urandom);
      r = 1'($urandom);
      hold(sp, l, r, len);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", longint'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
